// File: rtl/key_cond_pkg.sv
// Shared definitions for the key conditioner: repeat FSM encoding and default timing.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 20000000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_chan.sv
// One button channel: 2-FF synchroniser, counting debouncer and registered rise detector.
module key_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic btn_raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable_d;
    logic [CNT_W-1:0] db_cnt;

    always_ff @(posedge sysclk) begin
        if (!sysrst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            db_cnt   <= '0;
            rise     <= 1'b0;
        end else begin
            // synchroniser stage
            sync_p0  <= btn_raw;
            sync_p1  <= sync_p0;
            // debounce stage: any agreeing cycle restarts the count
            if (sync_p1 != stable) begin
                if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable <= sync_p1;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
            // edge stage
            stable_d <= stable;
            rise     <= stable & ~stable_d;
        end
    end

endmodule

// File: rtl/key_cond.sv
// Push-button conditioner: debounced single-cycle pulses, with hold-to-repeat on Next and Pre.
module key_cond
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic sysclk,
    input  logic sysrst_n,
    input  logic Btn_Next_raw,
    input  logic Btn_Pre_raw,
    input  logic Btn_Auto_raw,
    output logic Bt_Next,
    output logic Bt_Pre,
    output logic Bt_Auto
);

    localparam int RPT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic [2:0]       stable;
    logic [2:0]       rise;
    logic             both_held;
    rpt_state_t       state [2];
    logic [RPT_W-1:0] rpt_cnt [2];
    logic [1:0]       pulse;
    logic             auto_q;

    key_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .sysclk(sysclk), .sysrst_n(sysrst_n), .btn_raw(Btn_Next_raw),
        .stable(stable[0]), .rise(rise[0])
    );
    key_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pre (
        .sysclk(sysclk), .sysrst_n(sysrst_n), .btn_raw(Btn_Pre_raw),
        .stable(stable[1]), .rise(rise[1])
    );
    key_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_auto (
        .sysclk(sysclk), .sysrst_n(sysrst_n), .btn_raw(Btn_Auto_raw),
        .stable(stable[2]), .rise(rise[2])
    );

    // Holding Next and Pre together freezes both repeat timers.
    assign both_held = stable[0] & stable[1];

    always_ff @(posedge sysclk) begin
        if (!sysrst_n) begin
            for (int i = 0; i < 2; i++) begin
                state[i]   <= IDLE;
                rpt_cnt[i] <= '0;
            end
            pulse  <= '0;
            auto_q <= 1'b0;
        end else begin
            auto_q <= rise[2];
            for (int i = 0; i < 2; i++) begin
                pulse[i] <= 1'b0;
                case (state[i])
                    IDLE: begin
                        if (rise[i]) begin
                            state[i]   <= HOLD;
                            rpt_cnt[i] <= '0;
                            pulse[i]   <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (!stable[i]) begin
                            state[i]   <= IDLE;
                            rpt_cnt[i] <= '0;
                        end else if (both_held) begin
                            rpt_cnt[i] <= '0;
                        end else if (rpt_cnt[i] == RPT_W'(REPEAT_DELAY - 1)) begin
                            state[i]   <= REPEAT;
                            rpt_cnt[i] <= '0;
                            pulse[i]   <= 1'b1;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!stable[i]) begin
                            state[i]   <= IDLE;
                            rpt_cnt[i] <= '0;
                        end else if (both_held) begin
                            state[i]   <= HOLD;
                            rpt_cnt[i] <= '0;
                        end else if (rpt_cnt[i] == RPT_W'(REPEAT_PERIOD - 1)) begin
                            rpt_cnt[i] <= '0;
                            pulse[i]   <= 1'b1;
                        end else begin
                            rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        state[i]   <= IDLE;
                        rpt_cnt[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign Bt_Next = pulse[0];
    assign Bt_Pre  = pulse[1];
    assign Bt_Auto = auto_q;

endmodule

// File: tb/tb_key_cond.sv
// Bench for key_cond: directed scenario table, hand sequences and random stimulus against an event-time model.
module tb_key_cond;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic sysclk = 1'b0;
    logic sysrst_n = 1'b0;
    logic Btn_Next_raw = 1'b0, Btn_Pre_raw = 1'b0, Btn_Auto_raw = 1'b0;
    logic Bt_Next, Bt_Pre, Bt_Auto;

    always #5 sysclk = ~sysclk;

    key_cond #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .sysclk(sysclk), .sysrst_n(sysrst_n),
        .Btn_Next_raw(Btn_Next_raw), .Btn_Pre_raw(Btn_Pre_raw), .Btn_Auto_raw(Btn_Auto_raw),
        .Bt_Next(Bt_Next), .Bt_Pre(Bt_Pre), .Bt_Auto(Bt_Auto)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: sampled history per channel; repeat pulses derived from
    // the edge at which the press (or the last both-held edge) anchored timing.
    bit   m_s1[3], m_s2[3], m_st[3], m_std[3], m_rise[3];
    int   m_run[3];
    bit   m_act[2];
    int   m_anchor[2];
    int   edge_n = 0;
    bit [2:0] m_exp;

    int cnt_p[3];
    int first_p;
    int t_rel;

    task automatic model_edge(input bit rn, input bit [2:0] b);
        bit both;
        int d;
        both  = m_st[0] & m_st[1];
        m_exp = '0;
        if (!rn) begin
            for (int c = 0; c < 3; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_std[c] = 0; m_rise[c] = 0; m_run[c] = 0;
            end
            m_act[0] = 0;
            m_act[1] = 0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!m_act[c]) begin
                    if (m_rise[c]) begin
                        m_act[c] = 1; m_anchor[c] = edge_n; m_exp[c] = 1'b1;
                    end
                end else if (!m_st[c]) begin
                    m_act[c] = 0;
                end else if (both) begin
                    m_anchor[c] = edge_n;
                end else begin
                    d = edge_n - m_anchor[c];
                    if (d >= RD && ((d - RD) % RP) == 0) m_exp[c] = 1'b1;
                end
            end
            m_exp[2] = m_rise[2];
            for (int c = 0; c < 3; c++) begin
                m_rise[c] = m_st[c] & ~m_std[c];
                m_std[c]  = m_st[c];
                if (m_s2[c] != m_st[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_st[c]  = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = b[c];
            end
        end
        edge_n++;
    endtask

    // b[0]=Next, b[1]=Pre, b[2]=Auto
    task automatic step(input bit rn, input bit [2:0] b);
        bit [2:0] got;
        sysrst_n     = rn;
        Btn_Next_raw = b[0];
        Btn_Pre_raw  = b[1];
        Btn_Auto_raw = b[2];
        @(posedge sysclk);
        model_edge(rn, b);
        #1;
        got = {Bt_Auto, Bt_Pre, Bt_Next};
        checks++;
        if (got !== m_exp) begin
            errors++;
            $display("FAIL cycle_out edge %0d rel %0d: got %b want %b (auto,pre,next)", edge_n, t_rel, got, m_exp);
        end
        for (int c = 0; c < 3; c++) begin
            if (got[c] === 1'b1) begin
                cnt_p[c]++;
                if (first_p < 0) first_p = t_rel;
            end
        end
        t_rel++;
    endtask

    task automatic start_window();
        for (int c = 0; c < 3; c++) cnt_p[c] = 0;
        first_p = -1;
        t_rel   = 0;
    endtask

    task automatic check_window(input string name, input int n0, input int n1, input int n2, input int first);
        checks++;
        if (cnt_p[0] != n0) begin errors++; $display("FAIL %s next_count got %0d want %0d", name, cnt_p[0], n0); end
        checks++;
        if (cnt_p[1] != n1) begin errors++; $display("FAIL %s pre_count got %0d want %0d", name, cnt_p[1], n1); end
        checks++;
        if (cnt_p[2] != n2) begin errors++; $display("FAIL %s auto_count got %0d want %0d", name, cnt_p[2], n2); end
        checks++;
        if (first_p != first) begin errors++; $display("FAIL %s first_pulse got %0d want %0d", name, first_p, first); end
    endtask

    typedef struct {
        string    name;
        bit [2:0] btn;
        int       hold;
        int       rst_edge;
        int       n_next;
        int       n_pre;
        int       n_auto;
        int       first;
    } vec_t;

    vec_t vecs[5];
    bit [2:0] rb;

    initial begin
        for (int c = 0; c < 3; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_st[c] = 0; m_std[c] = 0; m_rise[c] = 0; m_run[c] = 0;
        end
        m_act[0] = 0; m_act[1] = 0; m_anchor[0] = 0; m_anchor[1] = 0;

        vecs[0] = '{"clean_press", 3'b001, 10, -1, 1, 0, 0, 7};
        vecs[1] = '{"hold_repeat", 3'b001, 60, -1, 6, 0, 0, 7};
        vecs[2] = '{"auto_hold",   3'b100, 100, -1, 0, 0, 1, 7};
        vecs[3] = '{"both_held",   3'b011, 60, -1, 1, 1, 0, 7};
        vecs[4] = '{"reset_mid",   3'b001, 60, 30, 4, 0, 0, 7};

        // Reset state
        start_window();
        for (int i = 0; i < 4; i++) step(1'b0, 3'b000);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b000);
        check_window("reset_state", 0, 0, 0, -1);

        foreach (vecs[v]) begin
            start_window();
            for (int t = 0; t < vecs[v].hold; t++) step(t == vecs[v].rst_edge ? 1'b0 : 1'b1, vecs[v].btn);
            for (int t = 0; t < 20; t++) step(1'b1, 3'b000);
            check_window(vecs[v].name, vecs[v].n_next, vecs[v].n_pre, vecs[v].n_auto, vecs[v].first);
        end

        // Bounce on Pre: no pulse while toggling, one pulse 7 edges after the final rise
        start_window();
        for (int t = 0; t < 20; t++) step(1'b1, ((t / 2) % 2 == 0) ? 3'b010 : 3'b000);
        for (int t = 0; t < 20; t++) step(1'b1, 3'b010);
        for (int t = 0; t < 20; t++) step(1'b1, 3'b000);
        check_window("bounce_pre", 0, 1, 0, 27);

        // Button already held while reset releases
        for (int t = 0; t < 3; t++) step(1'b0, 3'b001);
        start_window();
        for (int t = 0; t < 10; t++) step(1'b1, 3'b001);
        for (int t = 0; t < 20; t++) step(1'b1, 3'b000);
        check_window("held_thru_reset", 1, 0, 0, 7);

        // Random presses, bounces and occasional resets
        rb = '0;
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 29) == 0) rb[c] = ~rb[c];
            if ($urandom_range(0, 7) == 0) rb[$urandom_range(0, 2)] ^= 1'b1;
            step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
